rx_quadro_serial_7o1: RTL and testbench

//  Downstream partner of the SGA transmit path: receives the 6-character 7O1 serial frame
//  (STX, head, apple, state, modes, LF), checks it, and presents the decoded game snapshot.

---
 rtl/rx_quadro_serial_7o1_pkg.sv | 44 ++++
 rtl/rx_quadro_serial_7o1_rx.sv | 109 ++++++++++
 rtl/rx_quadro_serial_7o1.sv | 137 +++++++++++++
 tb/tb_rx_quadro_serial_7o1.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_quadro_serial_7o1_pkg.sv
// Shared constants and types for the 7O1 frame receiver.
// Values match the SGA transmit side.
package rx_quadro_serial_7o1_pkg;

  localparam logic [6:0] ASCII_STX = 7'h02;
  localparam logic [6:0] ASCII_LF  = 7'h0A;
  localparam logic [2:0] MODOS_TAG = 3'b001;

  localparam int BIT_COMEU = 6;
  localparam int BIT_DIFF  = 5;
  localparam int BIT_MODE  = 4;
  localparam int BIT_VEL   = 3;

  typedef enum logic [3:0] {
    ESPERA_STX = 4'd0,
    RX_HEAD    = 4'd1,
    RX_APPLE   = 4'd2,
    RX_STATE   = 4'd3,
    RX_MODOS   = 4'd4,
    ESPERA_LF  = 4'd5
  } frame_st_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_START,
    C_BITS,
    C_DONE
  } rx_st_e;

  typedef struct packed {
    logic [5:0] head;
    logic [5:0] apple;
    logic [5:0] state;
    logic       comeu;
    logic       diff;
    logic       mode;
    logic       vel;
  } snap_t;

  function automatic logic paridade_ok(input logic [6:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/rx_quadro_serial_7o1_rx.sv
// Character receiver for the 7O1 serial link.
// Synchronizes the line, times each bit, checks parity and stop.
module rx_quadro_serial_7o1_rx
  import rx_quadro_serial_7o1_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dados_ascii,
  output logic       char_pronto,
  output logic       char_erro
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  rx_st_e        st_q, st_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          pronto_q, pronto_d;
  logic          erro_q, erro_d;

  assign dados_ascii = shift_q[6:0];
  assign char_pronto = pronto_q;
  assign char_erro   = erro_q;

  // Bit timing: start edge counts as one elapsed cycle of the half bit
  always_comb begin
    sync1_d  = entrada_serial;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pronto_d = 1'b0;
    erro_d   = erro_q;
    unique case (st_q)
      C_IDLE: begin
        if (prev_q && !sync2_q) begin
          st_d  = C_START;
          cnt_d = CW'(1);
        end
      end
      C_START: begin
        if (cnt_q == MID) begin
          cnt_d = '0;
          idx_d = '0;
          st_d  = sync2_q ? C_IDLE : C_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      C_BITS: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd8) begin
            erro_d = !paridade_ok(shift_q[6:0], shift_q[7])
                     || !sync2_q;
            st_d   = C_DONE;
          end else begin
            shift_d = {sync2_q, shift_q[7:1]};
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      C_DONE: begin
        pronto_d = 1'b1;
        st_d     = C_IDLE;
      end
      default: st_d = C_IDLE;
    endcase
  end

  // Receiver state and synchronizer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q     <= C_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
    end
  end

endmodule

// File: rtl/rx_quadro_serial_7o1.sv
// 7O1 frame receiver: STX, head, apple, state, modes, LF.
// Outputs change only when a complete valid frame is accepted.
module rx_quadro_serial_7o1
  import rx_quadro_serial_7o1_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [5:0] head,
  output logic [5:0] apple,
  output logic [5:0] state,
  output logic       comeu_maca,
  output logic       difficulty,
  output logic       mode,
  output logic       velocity,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [3:0] db_estado
);

  logic [6:0] c;
  logic       char_pronto;
  logic       char_erro;
  logic       fmt_ok;
  frame_st_e  fr_q, fr_d;
  snap_t      sh_q, sh_d;
  snap_t      out_q, out_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  rx_quadro_serial_7o1_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dados_ascii    (c),
    .char_pronto    (char_pronto),
    .char_erro      (char_erro)
  );

  assign head        = out_q.head;
  assign apple       = out_q.apple;
  assign state       = out_q.state;
  assign comeu_maca  = out_q.comeu;
  assign difficulty  = out_q.diff;
  assign mode        = out_q.mode;
  assign velocity    = out_q.vel;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign db_estado   = fr_q;

  // Does the char fit the slot the frame is waiting for
  always_comb begin
    fmt_ok = 1'b0;
    unique case (fr_q)
      RX_HEAD, RX_APPLE, RX_STATE: fmt_ok = c[0];
      RX_MODOS:  fmt_ok = (c[2:0] == MODOS_TAG);
      ESPERA_LF: fmt_ok = (c == ASCII_LF);
      default:   fmt_ok = 1'b0;
    endcase
  end

  // Frame sequencing into shadows, publish on LF
  always_comb begin
    fr_d    = fr_q;
    sh_d    = sh_q;
    out_d   = out_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (char_pronto) begin
      if (fr_q == ESPERA_STX) begin
        if (!char_erro && c == ASCII_STX) fr_d = RX_HEAD;
      end else if (char_erro) begin
        error_d = 1'b1;
        fr_d    = ESPERA_STX;
        sh_d    = '0;
      end else if (c == ASCII_STX) begin
        error_d = 1'b1;
        fr_d    = RX_HEAD;
        sh_d    = '0;
      end else if (!fmt_ok) begin
        error_d = 1'b1;
        fr_d    = ESPERA_STX;
        sh_d    = '0;
      end else begin
        unique case (fr_q)
          RX_HEAD: begin
            sh_d.head = c[6:1];
            fr_d      = RX_APPLE;
          end
          RX_APPLE: begin
            sh_d.apple = c[6:1];
            fr_d       = RX_STATE;
          end
          RX_STATE: begin
            sh_d.state = c[6:1];
            fr_d       = RX_MODOS;
          end
          RX_MODOS: begin
            sh_d.comeu = c[BIT_COMEU];
            sh_d.diff  = c[BIT_DIFF];
            sh_d.mode  = c[BIT_MODE];
            sh_d.vel   = c[BIT_VEL];
            fr_d       = ESPERA_LF;
          end
          ESPERA_LF: begin
            out_d   = sh_q;
            valid_d = 1'b1;
            fr_d    = ESPERA_STX;
          end
          default: fr_d = ESPERA_STX;
        endcase
      end
    end
  end

  // Frame state, shadows, published snapshot and pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      fr_q    <= ESPERA_STX;
      sh_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      fr_q    <= fr_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_rx_quadro_serial_7o1.sv
// Bench for rx_quadro_serial_7o1: vector table, corner sequences,
// random frames against a char-level frame parser model.
module tb_rx_quadro_serial_7o1;

  localparam int CPB = 8;
  localparam int LAT = CPB / 2 + 9 * CPB + 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entrada_serial;
  logic [5:0] head, apple, state;
  logic       comeu_maca, difficulty, mode, velocity;
  logic       frame_valid, frame_error;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;

  int         m_pos = 0;
  int         m_valid = 0;
  int         m_err = 0;
  logic [6:0] m_buf [6];
  int         m_head = 0;
  int         m_apple = 0;
  int         m_state = 0;
  int         m_modes = 0;

  typedef struct {
    int              n;
    logic [0:8][6:0] ch;
    int              bad_at;
    bit              bad_stop;
    int              e_valid;
    int              e_err;
    int              e_head;
    int              e_apple;
    int              e_state;
    int              e_modes;
  } vec_t;

  vec_t tbl [9];

  rx_quadro_serial_7o1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clk),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .head           (head),
    .apple          (apple),
    .state          (state),
    .comeu_maca     (comeu_maca),
    .difficulty     (difficulty),
    .mode           (mode),
    .velocity       (velocity),
    .frame_valid    (frame_valid),
    .frame_error    (frame_error),
    .db_estado      (db_estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) begin
        n_valid <= n_valid + 1;
        last_valid_cyc <= cyc;
      end
      if (frame_error) n_err <= n_err + 1;
      if (frame_valid && frame_error) n_both <= n_both + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string t, input int eh, input int ea,
                         input int es, input int em);
    chk({t, "_head"}, head, eh);
    chk({t, "_apple"}, apple, ea);
    chk({t, "_state"}, state, es);
    chk({t, "_modes"}, {comeu_maca, difficulty, mode, velocity}, em);
  endtask

  task automatic wait_cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_head = 0;
    m_apple = 0;
    m_state = 0;
    m_modes = 0;
  endtask

  // Frame parser: slot 0 hunts for STX, slots 1..5 collect the frame
  task automatic model_char(input logic [6:0] c, input bit bad);
    bit ok;
    if (m_pos == 0) begin
      if (!bad && c == 7'h02) m_pos = 1;
    end else if (bad) begin
      m_err++;
      m_pos = 0;
    end else if (c == 7'h02) begin
      m_err++;
      m_pos = 1;
    end else begin
      if (m_pos <= 3) ok = (c % 2) == 1;
      else if (m_pos == 4) ok = (c % 8) == 1;
      else ok = (c == 7'h0A);
      if (!ok) begin
        m_err++;
        m_pos = 0;
      end else begin
        m_buf[m_pos] = c;
        if (m_pos == 5) begin
          m_valid++;
          m_head  = m_buf[1] / 2;
          m_apple = m_buf[2] / 2;
          m_state = m_buf[3] / 2;
          m_modes = m_buf[4] / 8;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic drive(input logic b);
    entrada_serial = b;
    wait_cyc(CPB);
  endtask

  task automatic send_char(input logic [6:0] c, input bit bad_par,
                           input bit bad_stop, input int gap);
    logic p;
    p = ~^c;
    if (bad_par) p = ~p;
    model_char(c, bad_par || bad_stop);
    start_cyc = cyc;
    drive(1'b0);
    for (int i = 0; i < 7; i++) drive(c[i]);
    drive(p);
    drive(!bad_stop);
    entrada_serial = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic do_reset();
    entrada_serial = 1'b1;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int v0, e0;
    tbl[0] = '{6, {7'h02, 7'h23, 7'h55, 7'h07, 7'h59, 7'h0A, 7'h00, 7'h00, 7'h00},
               -1, 1'b0, 1, 0, 17, 42, 3, 'b1011};
    tbl[1] = '{6, {7'h02, 7'h23, 7'h55, 7'h07, 7'h59, 7'h0A, 7'h00, 7'h00, 7'h00},
               2, 1'b0, 0, 1, 17, 42, 3, 'b1011};
    tbl[2] = '{6, {7'h02, 7'h0B, 7'h79, 7'h13, 7'h21, 7'h0A, 7'h00, 7'h00, 7'h00},
               -1, 1'b0, 1, 0, 5, 60, 9, 'b0100};
    tbl[3] = '{8, {7'h0A, 7'h41, 7'h02, 7'h7F, 7'h01, 7'h03, 7'h79, 7'h0A, 7'h00},
               -1, 1'b0, 1, 0, 63, 0, 1, 'b1111};
    tbl[4] = '{9, {7'h02, 7'h15, 7'h29, 7'h02, 7'h3D, 7'h3F, 7'h05, 7'h09, 7'h0A},
               -1, 1'b0, 1, 1, 30, 31, 2, 'b0001};
    tbl[5] = '{6, {7'h02, 7'h23, 7'h55, 7'h07, 7'h59, 7'h0A, 7'h00, 7'h00, 7'h00},
               5, 1'b1, 0, 1, 30, 31, 2, 'b0001};
    tbl[6] = '{6, {7'h02, 7'h23, 7'h55, 7'h07, 7'h59, 7'h0B, 7'h00, 7'h00, 7'h00},
               -1, 1'b0, 0, 1, 30, 31, 2, 'b0001};
    tbl[7] = '{6, {7'h02, 7'h23, 7'h55, 7'h07, 7'h5B, 7'h0A, 7'h00, 7'h00, 7'h00},
               -1, 1'b0, 0, 1, 30, 31, 2, 'b0001};
    tbl[8] = '{6, {7'h02, 7'h22, 7'h55, 7'h07, 7'h59, 7'h0A, 7'h00, 7'h00, 7'h00},
               -1, 1'b0, 0, 1, 30, 31, 2, 'b0001};

    reset = 1'b1;
    entrada_serial = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    wait_cyc(4);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_db", db_estado, 0);
    chk("reset_pulses", {frame_valid, frame_error}, 0);

    for (int r = 0; r < 9; r++) begin
      v0 = n_valid;
      e0 = n_err;
      for (int i = 0; i < tbl[r].n; i++)
        send_char(tbl[r].ch[i],
                  (tbl[r].bad_at == i) && !tbl[r].bad_stop,
                  (tbl[r].bad_at == i) && tbl[r].bad_stop, CPB);
      wait_cyc(2 * CPB);
      chk($sformatf("row%0d_valid", r), n_valid - v0, tbl[r].e_valid);
      chk($sformatf("row%0d_err", r), n_err - e0, tbl[r].e_err);
      chk_out($sformatf("row%0d", r), tbl[r].e_head, tbl[r].e_apple,
              tbl[r].e_state, tbl[r].e_modes);
      if (r == 0) chk("latency", last_valid_cyc - start_cyc, LAT);
    end

    v0 = n_valid;
    e0 = n_err;
    send_char(7'h02, 1'b0, 1'b0, CPB);
    entrada_serial = 1'b0;
    wait_cyc(2);
    entrada_serial = 1'b1;
    wait_cyc(3 * CPB);
    chk("glitch_db", db_estado, 1);
    send_char(7'h0B, 1'b0, 1'b0, CPB);
    send_char(7'h79, 1'b0, 1'b0, CPB);
    send_char(7'h13, 1'b0, 1'b0, CPB);
    send_char(7'h21, 1'b0, 1'b0, CPB);
    send_char(7'h0A, 1'b0, 1'b0, CPB);
    wait_cyc(2 * CPB);
    chk("glitch_valid", n_valid - v0, 1);
    chk("glitch_err", n_err - e0, 0);
    chk_out("glitch", 5, 60, 9, 'b0100);

    send_char(7'h02, 1'b0, 1'b0, CPB);
    send_char(7'h23, 1'b0, 1'b0, CPB);
    send_char(7'h55, 1'b0, 1'b0, CPB);
    send_char(7'h07, 1'b0, 1'b0, CPB);
    chk("premodos_db", db_estado, 4);
    entrada_serial = 1'b0;
    wait_cyc(3 * CPB);
    do_reset();
    wait_cyc(2 * CPB);
    chk_out("midrst", 0, 0, 0, 0);
    chk("midrst_db", db_estado, 0);
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 6; i++) send_char(tbl[0].ch[i], 1'b0, 1'b0, CPB);
    wait_cyc(2 * CPB);
    chk("postrst_valid", n_valid - v0, 1);
    chk("postrst_err", n_err - e0, 0);
    chk_out("postrst", 17, 42, 3, 'b1011);

    for (int r = 0; r < 25; r++) begin
      logic [6:0] fr [6];
      int fault, fpos, mv0, me0;
      bit bp, bs;
      v0 = n_valid;
      e0 = n_err;
      mv0 = m_valid;
      me0 = m_err;
      fr[0] = 7'h02;
      fr[1] = {6'($urandom_range(0, 63)), 1'b1};
      fr[2] = {6'($urandom_range(0, 63)), 1'b1};
      fr[3] = {6'($urandom_range(0, 63)), 1'b1};
      fr[4] = {4'($urandom_range(0, 15)), 3'b001};
      fr[5] = 7'h0A;
      fault = $urandom_range(0, 7);
      fpos = $urandom_range(0, 5);
      if (fault == 3) fr[fpos] = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0)
        send_char(7'($urandom_range(0, 127)), 1'b0, 1'b0, CPB);
      for (int i = 0; i < 6; i++) begin
        bp = (fault == 1) && (fpos == i);
        bs = (fault == 2) && (fpos == i);
        send_char(fr[i], bp, bs, bs ? CPB : $urandom_range(0, CPB));
      end
      wait_cyc(2 * CPB);
      chk($sformatf("rnd%0d_valid", r), n_valid - v0, m_valid - mv0);
      chk($sformatf("rnd%0d_err", r), n_err - e0, m_err - me0);
      chk_out($sformatf("rnd%0d", r), m_head, m_apple, m_state, m_modes);
    end

    chk("no_overlap", n_both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
